// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: 5-stage pipeline stall/flush/bubble control with divide wait, exception capture and halt.
module pipeline_sequencer #(
  parameter int ADDR_W = 16,
  parameter int REG_AW = 4,
  parameter int DIV_CYCLES = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs2,
  input  logic              id_jump,
  input  logic              ex_mem2r,
  input  logic              ex_reg_wr,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_is_div,
  input  logic              ex_branch_taken,
  input  logic              ex_halt,
  input  logic              ex_div0,
  input  logic              ex_overflow,
  input  logic [ADDR_W-1:0] ex_pc,
  output logic              pc_we,
  output logic              ifid_we,
  output logic              idex_we,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              exmem_bubble,
  output logic              div_start,
  output logic              halted,
  output logic              exc_valid,
  output logic [1:0]        exc_cause,
  output logic [ADDR_W-1:0] exc_pc,
  output logic [CNT_W-1:0]  stall_count
);
  typedef enum logic [1:0] {RUN, DIV_WAIT, HALTED} state_t;
  state_t state_q, state_d;
  logic [3:0] div_cnt_q, div_cnt_d;
  logic halted_q, halted_d, exc_valid_q, exc_valid_d;
  logic [1:0] exc_cause_q, exc_cause_d;
  logic [ADDR_W-1:0] exc_pc_q, exc_pc_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic exc, load_use;
  always_comb begin
    exc = ex_div0 | ex_overflow;
    load_use = ex_mem2r & ex_reg_wr & ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));
    pc_we = 1'b1;
    ifid_we = 1'b1;
    idex_we = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    exmem_bubble = 1'b0;
    div_start = 1'b0;
    state_d = state_q;
    div_cnt_d = div_cnt_q;
    halted_d = halted_q;
    exc_valid_d = exc_valid_q;
    exc_cause_d = exc_cause_q;
    exc_pc_d = exc_pc_q;
    if (state_q == HALTED) begin
      pc_we = 1'b0;
      ifid_we = 1'b0;
      idex_we = 1'b0;
      exmem_bubble = 1'b1;
    end else if (exc || ex_halt) begin
      pc_we = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      exmem_bubble = 1'b1;
      halted_d = 1'b1;
      state_d = HALTED;
      if (exc) begin
        exc_valid_d = 1'b1;
        exc_cause_d = {ex_overflow, ex_div0};
        exc_pc_d = ex_pc;
      end
    end else if (state_q == DIV_WAIT) begin
      if (div_cnt_q != 4'd0) begin
        pc_we = 1'b0;
        ifid_we = 1'b0;
        idex_we = 1'b0;
        exmem_bubble = 1'b1;
        div_cnt_d = div_cnt_q - 4'd1;
      end else begin
        state_d = RUN;
      end
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (ex_is_div) begin
      div_start = 1'b1;
      pc_we = 1'b0;
      ifid_we = 1'b0;
      idex_we = 1'b0;
      exmem_bubble = 1'b1;
      div_cnt_d = 4'(DIV_CYCLES - 1);
      state_d = DIV_WAIT;
    end else if (load_use) begin
      pc_we = 1'b0;
      ifid_we = 1'b0;
      idex_flush = 1'b1;
    end else if (id_jump) begin
      ifid_flush = 1'b1;
    end
    stall_count_d = (state_q != HALTED && !pc_we && !(&stall_count_q)) ? stall_count_q + 1'b1 : stall_count_q;
    if (rst) begin
      pc_we = 1'b0;
      ifid_we = 1'b0;
      idex_we = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      exmem_bubble = 1'b1;
      div_start = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      div_cnt_q <= '0;
      halted_q <= 1'b0;
      exc_valid_q <= 1'b0;
      exc_cause_q <= '0;
      exc_pc_q <= '0;
      stall_count_q <= '0;
    end else begin
      state_q <= state_d;
      div_cnt_q <= div_cnt_d;
      halted_q <= halted_d;
      exc_valid_q <= exc_valid_d;
      exc_cause_q <= exc_cause_d;
      exc_pc_q <= exc_pc_d;
      stall_count_q <= stall_count_d;
    end
  end
  assign halted = halted_q;
  assign exc_valid = exc_valid_q;
  assign exc_cause = exc_cause_q;
  assign exc_pc = exc_pc_q;
  assign stall_count = stall_count_q;
endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb_pipeline_sequencer: directed checks of hazards, divide wait, exceptions, halt and async reset.
module tb_pipeline_sequencer;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] id_rs1, id_rs2, ex_rd;
  logic id_uses_rs2, id_jump, ex_mem2r, ex_reg_wr, ex_is_div, ex_branch_taken, ex_halt, ex_div0, ex_overflow;
  logic [15:0] ex_pc;
  logic pc_we, ifid_we, idex_we, ifid_flush, idex_flush, exmem_bubble, div_start, halted, exc_valid;
  logic [1:0] exc_cause;
  logic [15:0] exc_pc, stall_count;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  pipeline_sequencer dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2), .id_jump(id_jump),
    .ex_mem2r(ex_mem2r), .ex_reg_wr(ex_reg_wr), .ex_rd(ex_rd), .ex_is_div(ex_is_div),
    .ex_branch_taken(ex_branch_taken), .ex_halt(ex_halt), .ex_div0(ex_div0), .ex_overflow(ex_overflow),
    .ex_pc(ex_pc), .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .exmem_bubble(exmem_bubble), .div_start(div_start), .halted(halted),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .stall_count(stall_count)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clr();
    {id_rs1, id_rs2, ex_rd, ex_pc} = '0;
    {id_uses_rs2, id_jump, ex_mem2r, ex_reg_wr, ex_is_div, ex_branch_taken, ex_halt, ex_div0, ex_overflow} = '0;
  endtask
  task automatic reset();
    rst = 1'b1;
    #1;
    tick();
    rst = 1'b0;
    #1;
  endtask
  task automatic chk_frozen(input logic [1:0] cause, input logic [15:0] pc, input logic [15:0] sc);
    {ex_branch_taken, ex_is_div, ex_div0, ex_overflow, ex_halt, id_jump} = 6'h3f;
    ex_pc = 16'hbeef;
    #1;
    chk("halt_pc_we", pc_we, 0);
    chk("halt_ifid_we", ifid_we, 0);
    chk("halt_bubble", exmem_bubble, 1);
    chk("halt_div_start", div_start, 0);
    repeat (2) tick();
    chk("frz_halted", halted, 1);
    chk("frz_cause", exc_cause, cause);
    chk("frz_pc", exc_pc, pc);
    chk("frz_stall", stall_count, sc);
    clr();
  endtask
  initial begin
    clr();
    #1;
    chk("rst_pc_we", pc_we, 0);
    chk("rst_idex_we", idex_we, 0);
    chk("rst_ifid_flush", ifid_flush, 1);
    chk("rst_idex_flush", idex_flush, 1);
    chk("rst_bubble", exmem_bubble, 1);
    chk("rst_div_start", div_start, 0);
    chk("rst_halted", halted, 0);
    chk("rst_stall", stall_count, 0);
    reset();
    chk("run_pc_we", pc_we, 1);
    chk("run_ifid_we", ifid_we, 1);
    chk("run_idex_we", idex_we, 1);
    chk("run_flush", ifid_flush, 0);
    // load-use on rs1
    ex_mem2r = 1; ex_reg_wr = 1; ex_rd = 3; id_rs1 = 3;
    #1;
    chk("lu_pc_we", pc_we, 0);
    chk("lu_ifid_we", ifid_we, 0);
    chk("lu_idex_flush", idex_flush, 1);
    tick(); clr(); #1;
    chk("lu_release", pc_we, 1);
    chk("lu_stall", stall_count, 1);
    // branch beats load-use
    ex_mem2r = 1; ex_reg_wr = 1; ex_rd = 3; id_rs1 = 3; ex_branch_taken = 1;
    #1;
    chk("br_pc_we", pc_we, 1);
    chk("br_ifid_we", ifid_we, 1);
    chk("br_ifid_flush", ifid_flush, 1);
    chk("br_idex_flush", idex_flush, 1);
    tick(); clr(); #1;
    chk("br_stall", stall_count, 1);
    id_jump = 1;
    #1;
    chk("jmp_ifid_flush", ifid_flush, 1);
    chk("jmp_idex_flush", idex_flush, 0);
    chk("jmp_pc_we", pc_we, 1);
    tick(); clr();
    // rs2 match only counts when rs2 is used
    ex_mem2r = 1; ex_reg_wr = 1; ex_rd = 7; id_rs1 = 1; id_rs2 = 7;
    #1;
    chk("rs2_unused", pc_we, 1);
    id_uses_rs2 = 1;
    #1;
    chk("rs2_used", pc_we, 0);
    tick(); clr(); #1;
    chk("rs2_stall", stall_count, 2);
    // divide: ex_is_div held high throughout to check no retrigger
    ex_is_div = 1;
    #1;
    chk("div_start", div_start, 1);
    chk("div_pc_we", pc_we, 0);
    chk("div_bubble", exmem_bubble, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      ex_branch_taken = (i == 1);
      #1;
      chk("divw_pc_we", pc_we, 0);
      chk("divw_start", div_start, 0);
      chk("divw_no_br", ifid_flush, 0);
    end
    tick(); ex_branch_taken = 0; #1;
    chk("div_rel_pc_we", pc_we, 1);
    chk("div_rel_start", div_start, 0);
    chk("div_rel_ifid_we", ifid_we, 1);
    tick(); clr(); #1;
    chk("div_stall", stall_count, 6);
    // divide with double fault in the release cycle
    ex_is_div = 1;
    tick(); clr();
    repeat (3) tick();
    ex_div0 = 1; ex_overflow = 1; ex_pc = 16'h1234;
    #1;
    chk("rel_exc_pc_we", pc_we, 0);
    chk("rel_exc_bubble", exmem_bubble, 1);
    tick(); clr(); #1;
    chk("rel_exc_halted", halted, 1);
    chk("rel_exc_valid", exc_valid, 1);
    chk("rel_exc_cause", exc_cause, 2'b11);
    chk("rel_exc_pc", exc_pc, 16'h1234);
    chk("rel_exc_stall", stall_count, 11);
    chk_frozen(2'b11, 16'h1234, 16'd11);
    // HALT opcode
    reset();
    chk("rst2_halted", halted, 0);
    chk("rst2_valid", exc_valid, 0);
    ex_halt = 1;
    #1;
    chk("hlt_pc_we", pc_we, 0);
    tick(); clr(); #1;
    chk("hlt_halted", halted, 1);
    chk("hlt_valid", exc_valid, 0);
    chk("hlt_cause", exc_cause, 0);
    // overflow fault
    reset();
    ex_overflow = 1; ex_pc = 16'h0042;
    #1;
    chk("ovf_pc_we", pc_we, 0);
    chk("ovf_bubble", exmem_bubble, 1);
    tick(); clr(); #1;
    chk("ovf_halted", halted, 1);
    chk("ovf_valid", exc_valid, 1);
    chk("ovf_cause", exc_cause, 2'b10);
    chk("ovf_pc", exc_pc, 16'h0042);
    chk_frozen(2'b10, 16'h0042, 16'd1);
    // async reset while div_cnt=2
    reset();
    ex_is_div = 1;
    tick(); clr();
    tick(); #1;
    chk("ar_pc_we", pc_we, 0);
    chk("ar_stall", stall_count, 2);
    #2 rst = 1;
    #1;
    chk("ar_stall0", stall_count, 0);
    chk("ar_halted0", halted, 0);
    chk("ar_pc_we_forced", pc_we, 0);
    chk("ar_div_start", div_start, 0);
    tick();
    rst = 0;
    #1;
    chk("ar_run_pc_we", pc_we, 1);
    chk("ar_run_start", div_start, 0);
    tick();
    chk("ar_run2_pc_we", pc_we, 1);
    tick();
    chk("ar_run3_stall", stall_count, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
